if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the address and instruction width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port imem_addr, output, 32, the fetch address to the combinational instruction memory; equals pc_q.
REQ-006 SHALL have port imem_rdata, input, 32, the instruction word returned in the same cycle for imem_addr.
REQ-007 SHALL have port redirect_valid, input, 1, the branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32, the redirect target.
REQ-009 SHALL have port id_ready, input, 1, meaning decode accepts the IF/ID register this cycle.
REQ-010 SHALL have port id_valid, output, 1, meaning the IF/ID register holds a valid instruction.
REQ-011 SHALL have port id_instr, output, 32, the registered instruction.
REQ-012 SHALL have port id_pc, output, 32, the address of id_instr.
REQ-013 SHALL have port id_pc_plus4, output, 32, equal to id_pc+4 modulo 2^32.
REQ-014 SHALL have port fault, output, 1, sticky misaligned-redirect flag.
REQ-015 SHALL have port fault_pc, output, 32, the offending redirect target.

Function
REQ-016 SHALL implement states FS_RUN and FS_FAULT; FS_RUN -> FS_FAULT on an accepted misaligned redirect; FS_FAULT is left only via rst.
REQ-017 SHALL define load = FS_RUN && !redirect_valid && (!id_valid || id_ready).
REQ-018 On load SHALL capture id_instr<=imem_rdata, id_pc<=pc_q, id_pc_plus4<=pc_q+4, set id_valid<=1, and advance pc_q<=pc_q+4.
REQ-019 On stall (FS_RUN, id_valid=1, id_ready=0, no redirect) SHALL hold pc_q and all id_* outputs unchanged.
REQ-020 In FS_RUN, FS_RUN && !redirect_valid && !load cannot clear id_valid; id_valid falls only by redirect, fault, or rst.
REQ-021 An aligned redirect (redirect_valid=1, redirect_pc[1:0]==0) in FS_RUN SHALL set pc_q<=redirect_pc, id_valid<=0, id_instr<=NOP, regardless of id_ready.
REQ-022 Redirect SHALL take priority over load in the same cycle; the instruction at the old pc_q is discarded.
REQ-023 Redirect latency: redirect in cycle N -> imem_addr=target in N+1 -> id_valid=1 with id_pc=target in N+2, provided id_ready allows.
REQ-024 A misaligned redirect (redirect_pc[1:0]!=0) in FS_RUN SHALL set fault<=1, fault_pc<=redirect_pc, id_valid<=0, state<=FS_FAULT, pc_q unchanged.
REQ-025 In FS_FAULT SHALL ignore redirect_valid and id_ready, keep id_valid=0, and hold pc_q, fault, and fault_pc.
REQ-026 pc_q and id_pc_plus4 SHALL wrap modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000) with no flag.
REQ-027 imem_addr SHALL be driven directly from pc_q with no combinational path from any input.

Reset
REQ-028 When rst=1 at a clock edge, SHALL override every other event (stall, redirect, fault).
REQ-029 On rst SHALL set pc_q=RESET_PC, state=FS_RUN, id_valid=0, id_instr=NOP (32'h0000_0013), id_pc=0, id_pc_plus4=0, fault=0, fault_pc=0.
REQ-030 The first load SHALL occur in the first cycle with rst=0, so id_valid=1 with id_pc=RESET_PC one cycle after rst deasserts.

Structure
REQ-031 The shared package riscv_pkg SHALL hold the NOP constant 32'h0000_0013, the default reset PC, and the enum fetch_state_e {FS_RUN, FS_FAULT}.
REQ-032 SHALL be a single flat module with no sub-module, instantiated beside instr_mem in the core top level.

Verification
REQ-033 Bench: rst then release, id_ready=1, mem[0..2]=A,B,C -> id_pc 0,4,8 with id_instr A,B,C on consecutive cycles, starting one cycle after release.
REQ-034 Bench: id_ready=0 for 3 cycles while id_pc=0x8 -> id_* stable, imem_addr holds 0xC; on release the next id_pc is 0xC.
REQ-035 Bench: redirect to 0x100 during a stall -> next cycle id_valid=0, imem_addr=0x100; the following cycle id_pc=0x100, id_pc_plus4=0x104.
REQ-036 Bench: redirect to 0x102 -> fault=1, fault_pc=0x102, id_valid=0; a later redirect to 0x200 is ignored; rst clears fault and refetches from RESET_PC.
REQ-037 Bench: RESET_PC=0xFFFF_FFFC -> id_pc=0xFFFF_FFFC with id_pc_plus4=0, then id_pc=0x0.
REQ-038 Bench: rst asserted during a stall with a simultaneous redirect -> next cycle id_valid=0, imem_addr=RESET_PC, fault=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the fetch front end.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FS_RUN   = 1'b0,
        FS_FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register with stall,
// redirect and sticky misaligned-redirect fault.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   FS_RUN   | fetching; loads IF/ID when decode frees it, takes redirects
//   FS_FAULT | misaligned redirect seen; frozen until rst
module if_stage
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  id_ready,
    output logic                  id_valid,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [DATA_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_pc_plus4,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] fault_pc
);

    localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP_INSTR);
    localparam logic [DATA_WIDTH-1:0] FOUR  = DATA_WIDTH'(4);

    fetch_state_e          state_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  load;
    logic                  redirect_aligned;

    assign imem_addr        = pc_q;
    assign redirect_aligned = (redirect_pc[1:0] == 2'b00);
    assign load = (state_q == FS_RUN) && !redirect_valid && (!id_valid || id_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FS_RUN;
            pc_q        <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= NOP_W;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            fault       <= 1'b0;
            fault_pc    <= '0;
        end else begin
            case (state_q)
                FS_RUN: begin
                    // Redirect wins over load; the word at the old pc_q is dropped.
                    if (redirect_valid) begin
                        id_valid <= 1'b0;
                        if (redirect_aligned) begin
                            pc_q     <= redirect_pc;
                            id_instr <= NOP_W;
                        end else begin
                            fault    <= 1'b1;
                            fault_pc <= redirect_pc;
                            state_q  <= FS_FAULT;
                        end
                    end else if (load) begin
                        id_valid    <= 1'b1;
                        id_instr    <= imem_rdata;
                        id_pc       <= pc_q;
                        id_pc_plus4 <= pc_q + FOUR;
                        pc_q        <= pc_q + FOUR;
                    end
                end
                FS_FAULT: begin
                    id_valid <= 1'b0;
                end
                default: begin
                    state_q  <= FS_FAULT;
                    id_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
